// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch inputs, hazard-unit controls, MEM/WB feedback
// and everything the decode stage presents to fetch, hazard unit and EX.
interface id_stage_if;
  // From fetch
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  // From hazard unit
  logic        StallD;
  logic        ForwardAD;
  logic        ForwardBD;
  // From MEM / WB stages
  logic [31:0] ALUOutM;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  // Decode results
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        BranchD;
  logic [5:0]  OpD;
  logic [5:0]  FunctD;
  logic [4:0]  RsD;
  logic [4:0]  RtD;
  logic [4:0]  RdD;
  logic [31:0] RD1D;
  logic [31:0] RD2D;
  logic [31:0] SignImmD;
  logic [31:0] PCPlus4D;

  // Surrounding pipeline: drives fetch/hazard/feedback, consumes decode results
  modport master (
    output InstrF, PCPlus4F, StallD, ForwardAD, ForwardBD,
           ALUOutM, RegWriteW, WriteRegW, ResultW,
    input  PCSrcD, PCBranchD, BranchD, OpD, FunctD, RsD, RtD, RdD,
           RD1D, RD2D, SignImmD, PCPlus4D
  );

  // Decode stage itself
  modport slave (
    input  InstrF, PCPlus4F, StallD, ForwardAD, ForwardBD,
           ALUOutM, RegWriteW, WriteRegW, ResultW,
    output PCSrcD, PCBranchD, BranchD, OpD, FunctD, RsD, RtD, RdD,
           RD1D, RD2D, SignImmD, PCPlus4D
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register with stall/flush, 32x32 register file
// with write-back bypass, and early beq/bne/j resolution that redirects fetch.
module id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [5:0]  OP_BEQ    = 6'h04,
  parameter logic [5:0]  OP_BNE    = 6'h05,
  parameter logic [5:0]  OP_J      = 6'h02
) (
  input  logic     clk,
  input  logic     rst_n,
  id_stage_if.slave bus
);

  // IF/ID state
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  // Decode fields
  logic [5:0]  op;
  logic [4:0]  rs, rt;
  logic [31:0] sign_imm;

  // Register file read side
  logic [31:0] rf_rd [32];
  logic [31:0] rd1, rd2;

  // Branch resolution
  logic [31:0] opnd_a, opnd_b;
  logic        equal;
  logic        is_beq, is_bne, is_j;
  logic        taken, pc_src;
  logic [31:0] pc_branch;

  assign op       = instr_q[31:26];
  assign rs       = instr_q[25:21];
  assign rt       = instr_q[20:16];
  assign sign_imm = {{16{instr_q[15]}}, instr_q[15:0]};

  // IF/ID next state: stall holds, a redirect squashes the wrong-path fetch
  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    if (!bus.StallD) begin
      if (pc_src) begin
        instr_d    = NOP_INSTR;
        pc_plus4_d = 32'h0;
      end else begin
        instr_d    = bus.InstrF;
        pc_plus4_d = bus.PCPlus4F;
      end
    end
  end

  // IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0;
    end else begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  // Register file: one flop word per entry; entry 0 is never written so it
  // stays at its reset value, and reads of $0 are forced to zero anyway.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_rf
      logic [31:0] entry_q, entry_d;
      logic        we;

      assign we = bus.RegWriteW && (bus.WriteRegW == 5'(gi)) && (gi != 0);

      // Write-back data replaces the entry when this register is targeted
      always_comb begin
        entry_d = entry_q;
        if (we) entry_d = bus.ResultW;
      end

      // Storage flop, cleared by reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry_q <= 32'h0;
        else        entry_q <= entry_d;
      end

      assign rf_rd[gi] = entry_q;
    end
  endgenerate

  // Read ports with same-cycle bypass of the write-back value
  always_comb begin
    rd1 = 32'h0;
    rd2 = 32'h0;
    if (rs != 5'd0) rd1 = rf_rd[rs];
    if (rt != 5'd0) rd2 = rf_rd[rt];
    if (bus.RegWriteW && (bus.WriteRegW != 5'd0) && (bus.WriteRegW == rs)) rd1 = bus.ResultW;
    if (bus.RegWriteW && (bus.WriteRegW != 5'd0) && (bus.WriteRegW == rt)) rd2 = bus.ResultW;
  end

  // Early branch compare with MEM forwarding, redirect decision and target
  always_comb begin
    opnd_a = bus.ForwardAD ? bus.ALUOutM : rd1;
    opnd_b = bus.ForwardBD ? bus.ALUOutM : rd2;
    equal  = (opnd_a == opnd_b);
    is_beq = (op == OP_BEQ);
    is_bne = (op == OP_BNE);
    is_j   = (op == OP_J);
    taken  = (is_beq & equal) | (is_bne & ~equal) | is_j;
    // A stalled branch must not redirect; it is re-evaluated once released
    pc_src = taken & ~bus.StallD;
    if (is_j) pc_branch = {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    else      pc_branch = pc_plus4_q + {sign_imm[29:0], 2'b00};
  end

  assign bus.PCSrcD    = pc_src;
  assign bus.PCBranchD = pc_branch;
  assign bus.BranchD   = is_beq | is_bne;
  assign bus.OpD       = op;
  assign bus.FunctD    = instr_q[5:0];
  assign bus.RsD       = rs;
  assign bus.RtD       = rt;
  assign bus.RdD       = instr_q[15:11];
  assign bus.RD1D      = rd1;
  assign bus.RD2D      = rd2;
  assign bus.SignImmD  = sign_imm;
  assign bus.PCPlus4D  = pc_plus4_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, write-back/bypass, beq/bne/j
// resolution, forwarding, target wrap, stall vs. flush.
module tb_id_stage;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  id_stage_if bus ();

  id_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end else begin
      $display("ok   %s: %08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc4);
    bus.InstrF   = instr;
    bus.PCPlus4F = pc4;
    tick();
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] v);
    bus.RegWriteW = 1'b1;
    bus.WriteRegW = r;
    bus.ResultW   = v;
    tick();
    bus.RegWriteW = 1'b0;
    #1;
  endtask

  localparam logic [31:0] ADD_10_8_9 = 32'h0109_5020; // add $10,$8,$9
  localparam logic [31:0] ADD_10_0_8 = 32'h0008_5020; // add $10,$0,$8
  localparam logic [31:0] BEQ_8_9_3  = 32'h1109_0003; // beq $8,$9,+3
  localparam logic [31:0] BNE_8_9_2  = 32'h1509_0002; // bne $8,$9,+2
  localparam logic [31:0] J_40       = 32'h0800_0040; // j 0x40
  localparam logic [31:0] BEQ_0_0_M1 = 32'h1000_FFFF; // beq $0,$0,-1
  localparam logic [31:0] BEQ_8_8_1  = 32'h1108_0001; // beq $8,$8,+1

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n         = 1'b0;
    bus.InstrF    = 32'h0;
    bus.PCPlus4F  = 32'h0;
    bus.StallD    = 1'b0;
    bus.ForwardAD = 1'b0;
    bus.ForwardBD = 1'b0;
    bus.ALUOutM   = 32'h0;
    bus.RegWriteW = 1'b0;
    bus.WriteRegW = 5'd0;
    bus.ResultW   = 32'h0;
    #12;

    // Reset state
    check("rst_pcsrc",  32'(bus.PCSrcD), 32'h0);
    check("rst_branch", 32'(bus.BranchD), 32'h0);
    check("rst_target", bus.PCBranchD, 32'h0);
    check("rst_op",     32'(bus.OpD), 32'h0);
    check("rst_pc4",    bus.PCPlus4D, 32'h0);
    check("rst_imm",    bus.SignImmD, 32'h0);

    // Release; first capture only after the next edge
    bus.InstrF   = ADD_10_8_9;
    bus.PCPlus4F = 32'h104;
    rst_n = 1'b1;
    #1;
    check("rel_no_capture", 32'(bus.RsD), 32'h0);
    tick();
    check("add_op",    32'(bus.OpD), 32'h0);
    check("add_funct", 32'(bus.FunctD), 32'h20);
    check("add_rs",    32'(bus.RsD), 32'h8);
    check("add_rt",    32'(bus.RtD), 32'h9);
    check("add_rd",    32'(bus.RdD), 32'ha);
    check("add_pc4",   bus.PCPlus4D, 32'h104);

    // Write-back bypass, then stored value (ID keeps reloading the add)
    bus.RegWriteW = 1'b1;
    bus.WriteRegW = 5'd8;
    bus.ResultW   = 32'hDEAD_BEEF;
    #1;
    check("bypass_rd1", bus.RD1D, 32'hDEAD_BEEF);
    tick();
    bus.RegWriteW = 1'b0;
    #1;
    check("stored_rd1", bus.RD1D, 32'hDEAD_BEEF);

    // Write to $0 is ignored and never bypassed
    load(ADD_10_0_8, 32'h108);
    bus.RegWriteW = 1'b1;
    bus.WriteRegW = 5'd0;
    bus.ResultW   = 32'h1234_5678;
    #1;
    check("r0_bypass", bus.RD1D, 32'h0);
    tick();
    bus.RegWriteW = 1'b0;
    #1;
    check("r0_stored", bus.RD1D, 32'h0);
    check("r0_rt_rd2", bus.RD2D, 32'hDEAD_BEEF);

    // beq taken: $8 == $9 == 5
    bus.InstrF = 32'h0;
    wb(5'd8, 32'd5);
    wb(5'd9, 32'd5);
    load(BEQ_8_9_3, 32'h104);
    check("beq_branchd", 32'(bus.BranchD), 32'h1);
    check("beq_pcsrc",   32'(bus.PCSrcD), 32'h1);
    check("beq_target",  bus.PCBranchD, 32'h110);
    load(ADD_10_8_9, 32'h108);
    check("beq_flush_rs",  32'(bus.RsD), 32'h0);
    check("beq_flush_pc4", bus.PCPlus4D, 32'h0);
    check("beq_flush_op",  32'(bus.OpD), 32'h0);

    // beq not taken: $9 = 6
    bus.InstrF = 32'h0;
    wb(5'd9, 32'd6);
    load(BEQ_8_9_3, 32'h104);
    check("beq_nt_pcsrc", 32'(bus.PCSrcD), 32'h0);
    load(ADD_10_8_9, 32'h108);
    check("beq_nt_rs",  32'(bus.RsD), 32'h8);
    check("beq_nt_pc4", bus.PCPlus4D, 32'h108);

    // bne with operand A forwarded from MEM, $9 = 7
    bus.InstrF = 32'h0;
    wb(5'd9, 32'd7);
    load(BNE_8_9_2, 32'h200);
    bus.ForwardAD = 1'b1;
    bus.ALUOutM   = 32'd7;
    #1;
    check("bne_fwd_eq_pcsrc", 32'(bus.PCSrcD), 32'h0);
    bus.ALUOutM = 32'd8;
    #1;
    check("bne_fwd_ne_pcsrc",  32'(bus.PCSrcD), 32'h1);
    check("bne_fwd_ne_target", bus.PCBranchD, 32'h208);
    load(32'h0, 32'h0);
    bus.ForwardAD = 1'b0;
    bus.ALUOutM   = 32'h0;

    // Forwarding on operand B: $8=5 vs ALUOutM=5 -> bne not taken
    load(BNE_8_9_2, 32'h200);
    bus.ForwardBD = 1'b1;
    bus.ALUOutM   = 32'd5;
    #1;
    check("bne_fwdb_pcsrc", 32'(bus.PCSrcD), 32'h0);
    bus.ForwardBD = 1'b0;
    bus.ALUOutM   = 32'h0;
    #1;
    load(32'h0, 32'h0);

    // Jump target keeps the upper PC nibble
    load(J_40, 32'h8000_0104);
    check("j_pcsrc",   32'(bus.PCSrcD), 32'h1);
    check("j_branchd", 32'(bus.BranchD), 32'h0);
    check("j_target",  bus.PCBranchD, 32'h8000_0100);
    load(32'h0, 32'h0);

    // Backward branch wrapping below zero
    load(BEQ_0_0_M1, 32'h0);
    check("wrap_imm",    bus.SignImmD, 32'hFFFF_FFFF);
    check("wrap_pcsrc",  32'(bus.PCSrcD), 32'h1);
    check("wrap_target", bus.PCBranchD, 32'hFFFF_FFFC);
    load(32'h0, 32'h0);

    // Taken beq held by a two-cycle stall
    load(BEQ_8_8_1, 32'h300);
    bus.StallD   = 1'b1;
    bus.InstrF   = ADD_10_8_9;
    bus.PCPlus4F = 32'h304;
    #1;
    check("stall0_pcsrc", 32'(bus.PCSrcD), 32'h0);
    for (int c = 1; c <= 2; c++) begin
      tick();
      check($sformatf("stall%0d_op", c),    32'(bus.OpD), 32'h4);
      check($sformatf("stall%0d_pc4", c),   bus.PCPlus4D, 32'h300);
      check($sformatf("stall%0d_pcsrc", c), 32'(bus.PCSrcD), 32'h0);
    end
    bus.StallD = 1'b0;
    #1;
    check("unstall_pcsrc",  32'(bus.PCSrcD), 32'h1);
    check("unstall_target", bus.PCBranchD, 32'h304);
    tick();
    check("unstall_flush_op",  32'(bus.OpD), 32'h0);
    check("unstall_flush_pc4", bus.PCPlus4D, 32'h0);

    // Mid-run reset clears everything and blocks write-back
    load(ADD_10_8_9, 32'h400);
    check("pre_rst_rd1", bus.RD1D, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rs",   32'(bus.RsD), 32'h0);
    check("mid_rst_imm",  bus.SignImmD, 32'h0);
    check("mid_rst_pc4",  bus.PCPlus4D, 32'h0);
    check("mid_rst_rd1",  bus.RD1D, 32'h0);
    bus.RegWriteW = 1'b1;
    bus.WriteRegW = 5'd8;
    bus.ResultW   = 32'h5555_5555;
    tick();
    bus.RegWriteW = 1'b0;
    rst_n = 1'b1;
    #1;
    tick();
    check("post_rst_rs",  32'(bus.RsD), 32'h8);
    check("post_rst_pc4", bus.PCPlus4D, 32'h400);
    check("post_rst_rd1", bus.RD1D, 32'h0);
    check("post_rst_rd2", bus.RD2D, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
